ex_hazard_forward_unit: RTL and testbench

Pipeline control block for the RV32IMA core.
- Tracks destination/control fields through EX, MEM and WB, and generates the EX-stage ALU operand forwarding selects that drive the alu_in_a/alu_in_b muxes.
- Detects load-use hazards, branch flushes and multi-cycle M-extension operations.
- Produces pipeline enables and flushes for the IF/ID and ID/EX registers.
- Sits between the decode stage and the EX operand muxes.

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/ex_hazard_forward_unit_fwd_sel_logic.sv | 29 ++
 rtl/ex_hazard_forward_unit.sv | 205 ++++++++++++++++++++
 tb/tb_ex_hazard_forward_unit.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared opcode constants, forwarding/FSM encodings and operand-use decode
// for the EX hazard and forwarding unit.
package hazard_pkg;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_AMO    = 7'h2F;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } md_state_t;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_REG) || (opcode == OP_STORE) ||
               (opcode == OP_BRANCH) || (opcode == OP_AMO);
    endfunction

endpackage

// File: rtl/ex_hazard_forward_unit_fwd_sel_logic.sv
// Per-operand forwarding select: MEM ALU result beats WB data, x0 and
// unused operands always read the register file.
module fwd_sel_logic
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] ex_rs,
    input  logic              rs_used,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_mem_to_reg,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_reg_write,
    output fwd_sel_t          fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (rs_used && (ex_rs != '0)) begin
            // A load in MEM has no ALU result to forward; it is caught by the stall.
            if (mem_reg_write && !mem_mem_to_reg && (mem_rd == ex_rs))
                fwd_sel = FWD_MEM;
            else if (wb_reg_write && (wb_rd == ex_rs))
                fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_hazard_forward_unit.sv
// EX-stage forwarding, load-use/branch/mul-div hazard control for the RV32IMA core.
// Optional HAZARD_WB_ID_BYPASS_EN adds WB->ID bypass selects for the decode read.
module ex_hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned MULDIV_MAX_CYC = 34
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_address_id_i,
    input  logic [ADDR_W-1:0] rs2_address_id_i,
    input  logic [ADDR_W-1:0] rd_address_id_i,
    input  logic [6:0]        opcode_id_i,
    input  logic              reg_write_id_i,
    input  logic              mem_to_reg_id_i,
    input  logic              muldiv_id_i,
    input  logic              branch_taken_ex_i,
    input  logic              muldiv_done_i,
    output logic [1:0]        alu_forward_a_o,
    output logic [1:0]        alu_forward_b_o,
    output logic              pc_en_o,
    output logic              if_id_en_o,
    output logic              ex_en_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic [ADDR_W-1:0] rd_address_mem_o,
    output logic [ADDR_W-1:0] rd_address_wb_o,
    output logic              reg_write_mem_o,
    output logic              reg_write_wb_o,
    output logic              muldiv_timeout_o
`ifdef HAZARD_WB_ID_BYPASS_EN
    ,
    output logic              id_bypass_a_o,
    output logic              id_bypass_b_o
`endif
);

    localparam logic [7:0] WD_LIMIT = 8'(MULDIV_MAX_CYC);

    logic [ADDR_W-1:0] rs1_ex, rs2_ex, rd_ex;
    logic [6:0]        opcode_ex;
    logic              reg_write_ex, mem_to_reg_ex, muldiv_ex;
    logic [ADDR_W-1:0] rd_mem, rd_wb;
    logic              reg_write_mem, mem_to_reg_mem, reg_write_wb;

    md_state_t  state;
    logic [7:0] wd_cnt;
    logic       timeout_q;
    fwd_sel_t   fwd_a, fwd_b, fwd_a_hold, fwd_b_hold;
    logic       load_use, wd_expire, md_stall;

    fwd_sel_logic #(.ADDR_W(ADDR_W)) u_fwd_a (
        .ex_rs          (rs1_ex),
        .rs_used        (uses_rs1(opcode_ex)),
        .mem_rd         (rd_mem),
        .mem_reg_write  (reg_write_mem),
        .mem_mem_to_reg (mem_to_reg_mem),
        .wb_rd          (rd_wb),
        .wb_reg_write   (reg_write_wb),
        .fwd_sel        (fwd_a)
    );

    fwd_sel_logic #(.ADDR_W(ADDR_W)) u_fwd_b (
        .ex_rs          (rs2_ex),
        .rs_used        (uses_rs2(opcode_ex)),
        .mem_rd         (rd_mem),
        .mem_reg_write  (reg_write_mem),
        .mem_mem_to_reg (mem_to_reg_mem),
        .wb_rd          (rd_wb),
        .wb_reg_write   (reg_write_wb),
        .fwd_sel        (fwd_b)
    );

    always_comb begin
        load_use = mem_to_reg_ex && (rd_ex != '0) &&
                   ((uses_rs1(opcode_id_i) && (rd_ex == rs1_address_id_i)) ||
                    (uses_rs2(opcode_id_i) && (rd_ex == rs2_address_id_i)));
        // wd_cnt excludes the IDLE entry cycle and the current cycle, hence +2:
        // expiry fires on the op's MULDIV_MAX_CYC-th cycle in EX without done.
        wd_expire = (state == MD_WAIT) && !muldiv_done_i && ((wd_cnt + 8'd2) == WD_LIMIT);
        if (state == IDLE)
            md_stall = muldiv_ex && !muldiv_done_i;
        else
            md_stall = !muldiv_done_i && !wd_expire;
    end

    always_comb begin
        pc_en_o         = 1'b1;
        if_id_en_o      = 1'b1;
        ex_en_o         = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        alu_forward_a_o = (state == MD_WAIT) ? fwd_a_hold : fwd_a;
        alu_forward_b_o = (state == MD_WAIT) ? fwd_b_hold : fwd_b;
        if (!reset) begin
            pc_en_o         = 1'b0;
            if_id_en_o      = 1'b0;
            ex_en_o         = 1'b0;
            if_id_flush_o   = 1'b1;
            id_ex_flush_o   = 1'b1;
            alu_forward_a_o = FWD_RF;
            alu_forward_b_o = FWD_RF;
        end else if (md_stall) begin
            pc_en_o    = 1'b0;
            if_id_en_o = 1'b0;
            ex_en_o    = 1'b0;
        end else if (branch_taken_ex_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (load_use) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wd_cnt     <= '0;
            timeout_q  <= 1'b0;
            fwd_a_hold <= FWD_RF;
            fwd_b_hold <= FWD_RF;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt     <= '0;
                    fwd_a_hold <= fwd_a;
                    fwd_b_hold <= fwd_b;
                    if (muldiv_ex && !muldiv_done_i)
                        state <= MD_WAIT;
                end
                MD_WAIT: begin
                    if (muldiv_done_i) begin
                        state  <= IDLE;
                        wd_cnt <= '0;
                    end else if (wd_expire) begin
                        state     <= IDLE;
                        wd_cnt    <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rs1_ex         <= '0;
            rs2_ex         <= '0;
            rd_ex          <= '0;
            opcode_ex      <= '0;
            reg_write_ex   <= 1'b0;
            mem_to_reg_ex  <= 1'b0;
            muldiv_ex      <= 1'b0;
            rd_mem         <= '0;
            reg_write_mem  <= 1'b0;
            mem_to_reg_mem <= 1'b0;
            rd_wb          <= '0;
            reg_write_wb   <= 1'b0;
        end else if (ex_en_o) begin
            if (id_ex_flush_o) begin
                rs1_ex        <= '0;
                rs2_ex        <= '0;
                rd_ex         <= '0;
                opcode_ex     <= '0;
                reg_write_ex  <= 1'b0;
                mem_to_reg_ex <= 1'b0;
                muldiv_ex     <= 1'b0;
            end else begin
                rs1_ex        <= rs1_address_id_i;
                rs2_ex        <= rs2_address_id_i;
                rd_ex         <= rd_address_id_i;
                opcode_ex     <= opcode_id_i;
                reg_write_ex  <= reg_write_id_i;
                mem_to_reg_ex <= mem_to_reg_id_i;
                muldiv_ex     <= muldiv_id_i;
            end
            rd_mem         <= rd_ex;
            reg_write_mem  <= reg_write_ex;
            mem_to_reg_mem <= mem_to_reg_ex;
            rd_wb          <= rd_mem;
            reg_write_wb   <= reg_write_mem;
        end else begin
            // MEM holds its instruction; WB sees a bubble so nothing retires twice.
            reg_write_wb <= 1'b0;
        end
    end

    assign rd_address_mem_o = rd_mem;
    assign rd_address_wb_o  = rd_wb;
    assign reg_write_mem_o  = reg_write_mem;
    assign reg_write_wb_o   = reg_write_wb;
    assign muldiv_timeout_o = timeout_q;

`ifdef HAZARD_WB_ID_BYPASS_EN
    assign id_bypass_a_o = reg_write_wb && (rd_wb != '0) && (rd_wb == rs1_address_id_i);
    assign id_bypass_b_o = reg_write_wb && (rd_wb != '0) && (rd_wb == rs2_address_id_i);
`endif

endmodule

// File: tb/tb_ex_hazard_forward_unit.sv
// Directed scenario bench for ex_hazard_forward_unit with an expectation queue.
module tb_ex_hazard_forward_unit;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_id, rs2_id, rd_id;
    logic [6:0] op_id;
    logic       rw_id, m2r_id, md_id, br, done;
    logic [1:0] fa, fb;
    logic       pc_en, ifid_en, ex_en, fl_if, fl_idex, tmo;
    logic [4:0] rd_mem, rd_wb;
    logic       rw_mem, rw_wb;

    always #5 clk = ~clk;

    ex_hazard_forward_unit #(.ADDR_W(5), .MULDIV_MAX_CYC(34)) dut (
        .clk(clk), .reset(reset),
        .rs1_address_id_i(rs1_id), .rs2_address_id_i(rs2_id), .rd_address_id_i(rd_id),
        .opcode_id_i(op_id), .reg_write_id_i(rw_id), .mem_to_reg_id_i(m2r_id),
        .muldiv_id_i(md_id), .branch_taken_ex_i(br), .muldiv_done_i(done),
        .alu_forward_a_o(fa), .alu_forward_b_o(fb),
        .pc_en_o(pc_en), .if_id_en_o(ifid_en), .ex_en_o(ex_en),
        .if_id_flush_o(fl_if), .id_ex_flush_o(fl_idex),
        .rd_address_mem_o(rd_mem), .rd_address_wb_o(rd_wb),
        .reg_write_mem_o(rw_mem), .reg_write_wb_o(rw_wb),
        .muldiv_timeout_o(tmo)
    );

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [15:0] obs(input int kind);
        if (kind == 0)
            return {6'd0, fa, fb, pc_en, ifid_en, ex_en, fl_if, fl_idex, tmo};
        return {4'd0, rd_mem, rw_mem, rd_wb, rw_wb};
    endfunction

    task automatic push_ctl(input string n, input logic [1:0] fa_e, input logic [1:0] fb_e,
                            input logic pc_e, input logic ifid_e, input logic ex_e,
                            input logic fif_e, input logic fidex_e, input logic tmo_e);
        exp_t e;
        e.name = n;
        e.kind = 0;
        e.val  = {6'd0, fa_e, fb_e, pc_e, ifid_e, ex_e, fif_e, fidex_e, tmo_e};
        sb.push_back(e);
    endtask

    task automatic push_pipe(input string n, input logic [4:0] rdm, input logic rwm,
                             input logic [4:0] rdw, input logic rww);
        exp_t e;
        e.name = n;
        e.kind = 1;
        e.val  = {4'd0, rdm, rwm, rdw, rww};
        sb.push_back(e);
    endtask

    task automatic set_id(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic [6:0] op, input logic rw, input logic m2r, input logic md);
        rs1_id = r1; rs2_id = r2; rd_id = rd; op_id = op;
        rw_id = rw; m2r_id = m2r; md_id = md;
    endtask

    task automatic nop();
        set_id(5'd0, 5'd0, 5'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick(); nop(); br = 1'b0; done = 1'b0;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b0; nop(); br = 1'b0; done = 1'b0;
        tick(); tick();
        push_ctl("reset_ctl", 2'b00, 2'b00, 0, 0, 0, 1, 1, 0);
        push_pipe("reset_pipe", 5'd0, 0, 5'd0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        tick(); reset = 1'b1;
        push_ctl("after_reset", 2'b00, 2'b00, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        idle(3);
    endtask

    task automatic test_fwd_mem();
        exp_t e;
        tick(); set_id(5'd1, 5'd2, 5'd5, OP_REG, 1, 0, 0);
        tick(); set_id(5'd5, 5'd5, 5'd6, OP_REG, 1, 0, 0);
        tick(); nop();
        push_ctl("fwd_mem_ab", 2'b10, 2'b10, 1, 1, 1, 0, 0, 0);
        push_pipe("mem_stage", 5'd5, 1, 5'd0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        tick(); nop();
        push_ctl("nop_no_fwd", 2'b00, 2'b00, 1, 1, 1, 0, 0, 0);
        push_pipe("wb_stage", 5'd6, 1, 5'd5, 1);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        idle(3);
    endtask

    task automatic test_priority();
        exp_t e;
        tick(); set_id(5'd1, 5'd2, 5'd5, OP_REG, 1, 0, 0);
        tick(); set_id(5'd3, 5'd4, 5'd5, OP_REG, 1, 0, 0);
        tick(); set_id(5'd5, 5'd0, 5'd9, OP_REG, 1, 0, 0);
        tick(); nop();
        push_ctl("mem_over_wb", 2'b10, 2'b00, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        idle(3);
        tick(); set_id(5'd1, 5'd2, 5'd10, OP_REG, 1, 0, 0);
        tick(); nop();
        tick(); set_id(5'd10, 5'd10, 5'd11, OP_REG, 1, 0, 0);
        tick(); nop();
        push_ctl("wb_only", 2'b01, 2'b01, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        idle(3);
    endtask

    task automatic test_load_use();
        exp_t e;
        tick(); set_id(5'd1, 5'd0, 5'd7, OP_LOAD, 1, 1, 0);
        tick(); set_id(5'd7, 5'd1, 5'd8, OP_REG, 1, 0, 0);
        push_ctl("ld_use_stall", 2'b00, 2'b00, 0, 0, 1, 0, 1, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        tick();
        push_ctl("ld_use_bubble", 2'b00, 2'b00, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        tick(); nop();
        push_ctl("ld_use_wb_fwd", 2'b01, 2'b00, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        idle(3);
        tick(); set_id(5'd1, 5'd0, 5'd7, OP_LOAD, 1, 1, 0);
        tick(); set_id(5'd7, 5'd7, 5'd9, OP_LUI, 1, 0, 0);
        push_ctl("ld_lui_no_stall", 2'b00, 2'b00, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        idle(3);
    endtask

    task automatic test_x0_lui();
        exp_t e;
        tick(); set_id(5'd1, 5'd2, 5'd0, OP_REG, 1, 0, 0);
        tick(); set_id(5'd0, 5'd0, 5'd3, OP_REG, 1, 0, 0);
        tick(); nop();
        push_ctl("x0_no_fwd", 2'b00, 2'b00, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        idle(3);
        tick(); set_id(5'd1, 5'd2, 5'd12, OP_REG, 1, 0, 0);
        tick(); set_id(5'd12, 5'd12, 5'd13, OP_LUI, 1, 0, 0);
        tick(); nop();
        push_ctl("lui_unused_rs", 2'b00, 2'b00, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        idle(3);
        tick(); set_id(5'd1, 5'd2, 5'd14, OP_REG, 1, 0, 0);
        tick(); set_id(5'd0, 5'd14, 5'd0, OP_STORE, 0, 0, 0);
        tick(); nop();
        push_ctl("store_rs2_fwd", 2'b00, 2'b10, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        idle(3);
    endtask

    task automatic test_muldiv_wait();
        exp_t e;
        tick(); set_id(5'd3, 5'd4, 5'd1, OP_REG, 1, 0, 0);
        tick(); nop();
        tick(); set_id(5'd1, 5'd2, 5'd15, OP_REG, 1, 0, 1);
        tick(); nop(); done = 1'b0;
        for (int i = 0; i < 33; i++) begin
            if (i > 0) tick();
            push_ctl("md_wait", 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front(); n_cmp++;
                if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, obs(e.kind), e.val); end
            end
        end
        tick(); done = 1'b1;
        push_ctl("md_done", 2'b01, 2'b00, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        tick(); done = 1'b0;
        push_ctl("md_resume", 2'b00, 2'b00, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        idle(3);
    endtask

    task automatic test_muldiv_fast();
        exp_t e;
        tick(); set_id(5'd3, 5'd4, 5'd16, OP_REG, 1, 0, 1);
        tick(); nop(); done = 1'b1;
        push_ctl("md_same_cycle", 2'b00, 2'b00, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        tick(); done = 1'b0;
        push_ctl("md_no_wait", 2'b00, 2'b00, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        idle(3);
    endtask

    task automatic test_branch_flush();
        exp_t e;
        tick(); set_id(5'd1, 5'd0, 5'd7, OP_LOAD, 1, 1, 0);
        tick(); set_id(5'd7, 5'd1, 5'd8, OP_REG, 1, 0, 0); br = 1'b1;
        push_ctl("br_over_lduse", 2'b00, 2'b00, 1, 1, 1, 1, 1, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        tick(); nop(); br = 1'b0;
        push_ctl("br_bubble", 2'b00, 2'b00, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        idle(3);
    endtask

    task automatic test_muldiv_timeout();
        exp_t e;
        tick(); set_id(5'd0, 5'd0, 5'd17, OP_REG, 1, 0, 1);
        tick(); nop(); done = 1'b0;
        for (int i = 0; i < 33; i++) begin
            if (i > 0) tick();
            push_ctl("wd_wait", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front(); n_cmp++;
                if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, obs(e.kind), e.val); end
            end
        end
        tick();
        push_ctl("wd_expire", 2'b00, 2'b00, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            push_ctl("wd_timeout_sticky", 2'b00, 2'b00, 1, 1, 1, 0, 0, 1);
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front(); n_cmp++;
                if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, obs(e.kind), e.val); end
            end
        end
        idle(3);
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        tick(); set_id(5'd3, 5'd4, 5'd2, OP_REG, 1, 0, 0);
        tick(); set_id(5'd2, 5'd2, 5'd18, OP_REG, 1, 0, 1);
        tick(); nop(); done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            push_ctl("md_wait_fwd", 2'b10, 2'b10, 0, 0, 0, 0, 0, 1);
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front(); n_cmp++;
                if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, obs(e.kind), e.val); end
            end
        end
        tick(); reset = 1'b0;
        push_ctl("reset_in_wait", 2'b00, 2'b00, 0, 0, 0, 1, 1, 1);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
        tick(); reset = 1'b1;
        push_ctl("reset_to_idle", 2'b00, 2'b00, 1, 1, 1, 0, 0, 0);
        push_pipe("reset_pipe_clear", 5'd0, 0, 5'd0, 0);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs(e.kind) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(e.kind), e.val); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got no summary, required finish before 200000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fwd_mem();
        test_priority();
        test_load_use();
        test_x0_lui();
        test_muldiv_wait();
        test_muldiv_fast();
        test_branch_flush();
        test_muldiv_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
